ofs_plat_prim_burstcount1_write_arbiter: RTL and testbench
==========================================================

Name: ofs_plat_prim_burstcount1_write_arbiter

Overview:
- Round-robin arbiter that shares one Avalon-style write channel among N_REQ requesters.
- Burst lengths use origin-1 encoding: 1 = one beat, 0 = illegal.
- A grant is locked from the SOP beat through the EOP beat, so bursts from different requesters never interleave.
- Sits between per-port write request channels and a single downstream memory write channel. Zero-latency, combinational datapath mux.

Parameters:
- N_REQ, 4, number of requesters (≥1).
- BURST_CNT_WIDTH, 7, width of burstcount fields.
- DATA_WIDTH, 512, width of write data per beat.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester beat valid.
- req_burstcount  in  N_REQ*BURST_CNT_WIDTH  per-requester burst length; sampled only at SOP.
- req_data  in  N_REQ*DATA_WIDTH  per-requester write data.
- req_ready  out  N_REQ  per-requester beat accepted.
- out_valid  out  1  downstream beat valid.
- out_burstcount  out  BURST_CNT_WIDTH  burstcount of the granted requester.
- out_data  out  DATA_WIDTH  data of the granted requester.
- out_grant  out  max(1,$clog2(N_REQ))  index of the granted requester.
- out_sop  out  1  current out beat is first of a burst.
- out_eop  out  1  current out beat is last of a burst.
- out_ready  in  1  downstream accepts beat.
- err_burst0  out  1  sticky illegal-burstcount flag (see Optional Feature).

Behaviour:
- Transfer: out_valid && out_ready. req_ready[i] = out_ready && (out_grant==i) && !reset; never asserted for a non-granted port.
- State: IDLE (no lock) / LOCKED (grant fixed). Registers: state, locked_idx, rr_ptr, flits_rem.
- IDLE:
  - Winner = first requester with req_valid set, searching from rr_ptr upward modulo N_REQ.
  - out_grant = winner; out_valid = any req_valid; out_sop = 1.
  - If no requester is valid: out_grant = rr_ptr, out_valid = 0.
- IDLE, SOP transfer with burstcount > 1: go to LOCKED; locked_idx ← winner; flits_rem ← burstcount−1.
- IDLE, SOP transfer with burstcount == 1: beat is both SOP and EOP; stay IDLE; rr_ptr ← (winner+1) mod N_REQ.
- LOCKED:
  - out_grant = locked_idx; out_valid = req_valid[locked_idx]; out_sop = 0.
  - Other requesters are ignored even while the locked port deasserts valid (bubbles allowed).
  - Each transfer decrements flits_rem by 1.
  - Transfer with flits_rem == 1 → return to IDLE; rr_ptr ← (locked_idx+1) mod N_REQ.
- out_eop = (out_sop && out_burstcount==1) || (!out_sop && flits_rem==1).
- out_burstcount / out_data are muxed from the granted port every cycle. Downstream must sample burstcount only at SOP.
- No state change without a transfer. A valid beat held under out_ready=0 keeps the same grant; IDLE winner selection is stable because rr_ptr is unchanged.
- Arithmetic: flits_rem is BURST_CNT_WIDTH bits. Maximum burst is 2^BURST_CNT_WIDTH−1.
- Reset (also mid-burst): state ← IDLE, rr_ptr ← 0, flits_rem ← 0, locked_idx ← 0, err_burst0 ← 0. While reset_n=0, out_valid=0 and req_ready=0. After reset, out_sop=1, out_eop=0 (no valid).
- N_REQ=1: rr_ptr is held at 0, and the block degenerates to an SOP/EOP tracker pass-through.

Optional Feature:
- Macro: OFS_PLAT_BURST_ARB_CHECK_EN.
- Defined:
  - An SOP transfer with out_burstcount==0 sets err_burst0 (sticky until reset).
  - That beat is then treated as a single-beat burst: stay IDLE, advance rr_ptr.
  - A simulation $error is issued.
- Undefined: err_burst0 is tied to 0, no check logic is built, and burstcount==0 behaviour is undefined.

Test Plan:
- Single requester 0, burstcount=3, out_ready=1 → 3 transfers on grant 0; sop on beat 1, eop on beat 3; rr_ptr=1 afterwards.
- Requesters 0 and 2 valid together, both burstcount=2, out_ready=1 → grant order 0,0,2,2; req_ready[2]=0 during requester 0's burst.
- Requester 1 burstcount=4, req_valid[1] dropped after beat 2 for 3 cycles while requester 3 is valid → grant stays 1 and out_valid=0 during the gap; requester 3 is granted only after beat 4 (eop).
- Back-to-back burstcount=1 from all 4 requesters → grants 0,1,2,3,0 in consecutive cycles, each beat sop=eop=1.
- out_ready=0 for 5 cycles with requester 2 valid at SOP → grant 2 held and out_sop=1 throughout; no state change; beat transfers in the first cycle with out_ready=1.
- reset_n=0 in the middle of a burstcount=4 burst (after beat 2) → state IDLE and rr_ptr=0; next burst starts with sop=1. With CHECK_EN, a burstcount=0 SOP beat → err_burst0=1 until reset.

Source files
------------

// File: rtl/ofs_plat_prim_burstcount1_write_arbiter_if.sv
// Bundle of the per-requester write channels and the shared downstream write channel.
// The arbiter connects through the slave modport; the requester/downstream side uses master.
interface ofs_plat_prim_burstcount1_write_arbiter_if #(
  parameter int N_REQ           = 4,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int DATA_WIDTH      = 512
);
  localparam int GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ*BURST_CNT_WIDTH-1:0] req_burstcount;
  logic [N_REQ*DATA_WIDTH-1:0]      req_data;
  logic [N_REQ-1:0]                 req_ready;

  logic                             out_valid;
  logic [BURST_CNT_WIDTH-1:0]       out_burstcount;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [GRANT_W-1:0]               out_grant;
  logic                             out_sop;
  logic                             out_eop;
  logic                             out_ready;
  logic                             err_burst0;

  modport slave (
    input  req_valid, req_burstcount, req_data, out_ready,
    output req_ready, out_valid, out_burstcount, out_data, out_grant,
    output out_sop, out_eop, err_burst0
  );

  modport master (
    output req_valid, req_burstcount, req_data, out_ready,
    input  req_ready, out_valid, out_burstcount, out_data, out_grant,
    input  out_sop, out_eop, err_burst0
  );
endinterface

// File: rtl/ofs_plat_prim_burstcount1_write_arbiter.sv
// Round-robin write arbiter that locks the grant for a whole burst (SOP through EOP).
// Optional burstcount==0 checking is built when OFS_PLAT_BURST_ARB_CHECK_EN is defined.
module ofs_plat_prim_burstcount1_write_arbiter #(
  parameter int N_REQ           = 4,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int DATA_WIDTH      = 512
) (
  input  logic clk,
  input  logic reset_n,
  ofs_plat_prim_burstcount1_write_arbiter_if.slave bus
);
  localparam int GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW      = GRANT_W + 1;
  localparam logic [CW-1:0] N_REQ_L = CW'(N_REQ);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]                 state_reg;
  logic [GRANT_W-1:0]         locked_idx_reg;
  logic [GRANT_W-1:0]         rr_ptr_reg;
  logic [BURST_CNT_WIDTH-1:0] flits_rem_reg;

  logic [DATA_WIDTH-1:0]      data_arr [N_REQ];
  logic [BURST_CNT_WIDTH-1:0] bc_arr   [N_REQ];

  logic [GRANT_W-1:0]         win_idx;
  logic                       win_found;
  logic [CW-1:0]              cand;
  logic [GRANT_W-1:0]         grant;
  logic [BURST_CNT_WIDTH-1:0] bc_sel;
  logic                       valid_sel;
  logic                       xfer;

  function automatic logic [GRANT_W-1:0] next_ptr(input logic [GRANT_W-1:0] p);
    return (p == GRANT_W'(N_REQ - 1)) ? '0 : p + GRANT_W'(1);
  endfunction

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
    assign data_arr[gi]      = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign bc_arr[gi]        = bus.req_burstcount[gi*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
    assign bus.req_ready[gi] = reset_n && bus.out_ready && (grant == GRANT_W'(gi));
  end

  // Search starts at rr_ptr and wraps; with nobody valid the grant rests on rr_ptr.
  always_comb begin
    win_idx   = rr_ptr_reg;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + CW'(k);
      if (cand >= N_REQ_L) cand = cand - N_REQ_L;
      if (!win_found && bus.req_valid[cand[GRANT_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GRANT_W-1:0];
      end
    end
  end

  assign grant     = (state_reg == ST_LOCKED) ? locked_idx_reg : win_idx;
  assign valid_sel = (state_reg == ST_LOCKED) ? bus.req_valid[locked_idx_reg] : win_found;
  assign bc_sel    = bc_arr[grant];
  assign xfer      = bus.out_valid && bus.out_ready;

  assign bus.out_valid      = reset_n && valid_sel;
  assign bus.out_grant      = grant;
  assign bus.out_burstcount = bc_sel;
  assign bus.out_data       = data_arr[grant];
  assign bus.out_sop        = (state_reg == ST_IDLE);
  // EOP is only meaningful alongside a valid beat, so it stays low on idle cycles.
  assign bus.out_eop        = bus.out_valid &&
                              (((state_reg == ST_IDLE) && (bc_sel == BURST_CNT_WIDTH'(1))) ||
                               ((state_reg == ST_LOCKED) && (flits_rem_reg == BURST_CNT_WIDTH'(1))));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      locked_idx_reg <= '0;
      rr_ptr_reg     <= '0;
      flits_rem_reg  <= '0;
    end else if (xfer) begin
      if (state_reg == ST_IDLE) begin
        // Single-beat (and illegal zero-length) bursts never take the lock.
        if (bc_sel > BURST_CNT_WIDTH'(1)) begin
          state_reg      <= ST_LOCKED;
          locked_idx_reg <= win_idx;
          flits_rem_reg  <= bc_sel - BURST_CNT_WIDTH'(1);
        end else begin
          rr_ptr_reg <= next_ptr(win_idx);
        end
      end else begin
        flits_rem_reg <= flits_rem_reg - BURST_CNT_WIDTH'(1);
        if (flits_rem_reg == BURST_CNT_WIDTH'(1)) begin
          state_reg  <= ST_IDLE;
          rr_ptr_reg <= next_ptr(locked_idx_reg);
        end
      end
    end
  end

`ifdef OFS_PLAT_BURST_ARB_CHECK_EN
  logic err_burst0_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_burst0_reg <= 1'b0;
    end else if (xfer && (state_reg == ST_IDLE) && (bc_sel == '0)) begin
      err_burst0_reg <= 1'b1;
      $error("burstcount 0 at SOP from requester %0d", win_idx);
    end
  end

  assign bus.err_burst0 = err_burst0_reg;
`else
  assign bus.err_burst0 = 1'b0;
`endif
endmodule

// File: tb/tb_ofs_plat_prim_burstcount1_write_arbiter.sv
// Directed bench for the burst-locking round-robin write arbiter (N_REQ=4).
module tb_ofs_plat_prim_burstcount1_write_arbiter;
  localparam int N  = 4;
  localparam int BW = 7;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic reset_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  ofs_plat_prim_burstcount1_write_arbiter_if #(.N_REQ(N), .BURST_CNT_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

  ofs_plat_prim_burstcount1_write_arbiter #(.N_REQ(N), .BURST_CNT_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hDA7A_0000 + 32'(i);
    return {16{w}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input int bc);
    bus.req_valid[i] = v;
    bus.req_burstcount[i*BW +: BW] = BW'(bc);
  endtask

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] e;
    e = '0;
    e[g] = 1'b1;
    return e;
  endfunction

  // Checks one accepted beat (out_ready=1), then advances to the next negedge.
  task automatic beat(input string tag, input int g, input logic sop, input logic eop);
    #1;
    $display("beat %s: grant=%0d sop=%0b eop=%0b valid=%0b", tag, bus.out_grant, bus.out_sop, bus.out_eop, bus.out_valid);
    chk({tag, ".valid"}, DW'(bus.out_valid), DW'(1));
    chk({tag, ".grant"}, DW'(bus.out_grant), DW'(g));
    chk({tag, ".sop"}, DW'(bus.out_sop), DW'(sop));
    chk({tag, ".eop"}, DW'(bus.out_eop), DW'(eop));
    chk({tag, ".ready"}, DW'(bus.req_ready), DW'(onehot(g)));
    chk({tag, ".data"}, bus.out_data, pat(g));
    @(negedge clk);
  endtask

  // Checks an idle cycle: nothing valid, grant parked on the round-robin pointer.
  task automatic idle(input string tag, input int g);
    #1;
    $display("idle %s: grant=%0d sop=%0b eop=%0b valid=%0b", tag, bus.out_grant, bus.out_sop, bus.out_eop, bus.out_valid);
    chk({tag, ".valid"}, DW'(bus.out_valid), DW'(0));
    chk({tag, ".grant"}, DW'(bus.out_grant), DW'(g));
    chk({tag, ".sop"}, DW'(bus.out_sop), DW'(1));
    chk({tag, ".eop"}, DW'(bus.out_eop), DW'(0));
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_burstcount = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = pat(i);

    // In reset with everyone requesting: nothing may be offered or accepted.
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1);
    #1;
    chk("rst.valid", DW'(bus.out_valid), DW'(0));
    chk("rst.ready", DW'(bus.req_ready), DW'(0));
    @(negedge clk);
    reset_n = 1'b1;
    bus.req_valid = '0;
    idle("post_rst", 0);
    chk("post_rst.err", DW'(bus.err_burst0), DW'(0));

    // Requesters 0 and 2 with 2-beat bursts: 0,0 then 2,2.
    set_req(0, 1'b1, 2); set_req(2, 1'b1, 2);
    beat("t2.b0", 0, 1'b1, 1'b0);
    beat("t2.b1", 0, 1'b0, 1'b1);
    set_req(0, 1'b0, 2);
    beat("t2.b2", 2, 1'b1, 1'b0);
    beat("t2.b3", 2, 1'b0, 1'b1);
    set_req(2, 1'b0, 2);
    idle("t2.end", 3);

    // Single requester 0, 3-beat burst; pointer ends at 1.
    set_req(0, 1'b1, 3);
    beat("t1.b0", 0, 1'b1, 1'b0);
    beat("t1.b1", 0, 1'b0, 1'b0);
    beat("t1.b2", 0, 1'b0, 1'b1);
    set_req(0, 1'b0, 3);
    idle("t1.end", 1);

    // Requester 1 4-beat burst with a 3-cycle bubble while requester 3 waits.
    set_req(1, 1'b1, 4); set_req(3, 1'b1, 1);
    beat("t3.b0", 1, 1'b1, 1'b0);
    beat("t3.b1", 1, 1'b0, 1'b0);
    set_req(1, 1'b0, 4);
    for (int c = 0; c < 3; c++) begin
      #1;
      $display("gap %0d: grant=%0d sop=%0b valid=%0b", c, bus.out_grant, bus.out_sop, bus.out_valid);
      chk("t3.gap.valid", DW'(bus.out_valid), DW'(0));
      chk("t3.gap.grant", DW'(bus.out_grant), DW'(1));
      chk("t3.gap.sop", DW'(bus.out_sop), DW'(0));
      chk("t3.gap.ready", DW'(bus.req_ready), DW'(4'b0010));
      @(negedge clk);
    end
    set_req(1, 1'b1, 4);
    beat("t3.b2", 1, 1'b0, 1'b0);
    beat("t3.b3", 1, 1'b0, 1'b1);
    set_req(1, 1'b0, 4);
    beat("t3.r3", 3, 1'b1, 1'b1);
    set_req(3, 1'b0, 1);
    idle("t3.end", 0);

    // Back-to-back single beats from everyone.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1);
    beat("t4.b0", 0, 1'b1, 1'b1);
    beat("t4.b1", 1, 1'b1, 1'b1);
    beat("t4.b2", 2, 1'b1, 1'b1);
    beat("t4.b3", 3, 1'b1, 1'b1);
    beat("t4.b4", 0, 1'b1, 1'b1);
    bus.req_valid = '0;
    idle("t4.end", 1);

    // Backpressure at SOP: requester 2 held for 5 cycles, then accepted.
    set_req(2, 1'b1, 1);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      $display("stall %0d: grant=%0d sop=%0b valid=%0b", c, bus.out_grant, bus.out_sop, bus.out_valid);
      chk("t5.stall.valid", DW'(bus.out_valid), DW'(1));
      chk("t5.stall.grant", DW'(bus.out_grant), DW'(2));
      chk("t5.stall.sop", DW'(bus.out_sop), DW'(1));
      chk("t5.stall.ready", DW'(bus.req_ready), DW'(0));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    beat("t5.go", 2, 1'b1, 1'b1);
    set_req(2, 1'b0, 1);
    idle("t5.end", 3);

    // Reset in the middle of a 4-beat burst from requester 0.
    set_req(0, 1'b1, 4);
    beat("t6.b0", 0, 1'b1, 1'b0);
    beat("t6.b1", 0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t6.rst.valid", DW'(bus.out_valid), DW'(0));
    chk("t6.rst.ready", DW'(bus.req_ready), DW'(0));
    @(negedge clk);
    reset_n = 1'b1;
    set_req(0, 1'b0, 4);
    idle("t6.idle", 0);
    set_req(0, 1'b1, 2);
    beat("t6.n0", 0, 1'b1, 1'b0);
    beat("t6.n1", 0, 1'b0, 1'b1);
    set_req(0, 1'b0, 2);
    idle("t6.end", 1);

`ifdef OFS_PLAT_BURST_ARB_CHECK_EN
    // Zero-length SOP beat: sticky error, treated as a single beat.
    set_req(1, 1'b1, 0);
    #1;
    chk("t7.grant", DW'(bus.out_grant), DW'(1));
    @(negedge clk);
    set_req(1, 1'b0, 0);
    idle("t7.end", 2);
    chk("t7.err", DW'(bus.err_burst0), DW'(1));
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t7.err_clr", DW'(bus.err_burst0), DW'(0));
`else
    chk("t7.err_tied", DW'(bus.err_burst0), DW'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
